// File: rtl/picorv32_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : picorv32_axi_sram_slave
// Description : AXI4-lite slave bridging a core's memory port to one
//               synchronous single-port SRAM, with out-of-window absorption.
// Revision    : 1.0 - initial release
// ============================================================================
module picorv32_axi_sram_slave #(
    parameter logic [31:0] ADDR_BASE     = 32'h0000_0000,
    parameter int          MEM_ADDR_BITS = 14,
    parameter int          READ_LATENCY  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_axi_awvalid,
    output logic                     mem_axi_awready,
    input  logic [31:0]              mem_axi_awaddr,
    input  logic [2:0]               mem_axi_awprot,
    input  logic                     mem_axi_wvalid,
    output logic                     mem_axi_wready,
    input  logic [31:0]              mem_axi_wdata,
    input  logic [3:0]               mem_axi_wstrb,
    output logic                     mem_axi_bvalid,
    input  logic                     mem_axi_bready,
    input  logic                     mem_axi_arvalid,
    output logic                     mem_axi_arready,
    input  logic [31:0]              mem_axi_araddr,
    input  logic [2:0]               mem_axi_arprot,
    output logic                     mem_axi_rvalid,
    input  logic                     mem_axi_rready,
    output logic [31:0]              mem_axi_rdata,
    output logic                     sram_en,
    output logic [3:0]               sram_we,
    output logic [MEM_ADDR_BITS-1:0] sram_addr,
    output logic [31:0]              sram_wdata,
    input  logic [31:0]              sram_rdata,
    output logic                     decode_err,
    output logic [7:0]               err_count
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_WRESP    = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RRESP    = 3'd5
    } state_t;

    localparam logic [31:0] c_win_mask  = 32'((64'd4 << MEM_ADDR_BITS) - 64'd1);
    localparam logic [2:0]  c_wait_init = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

    state_t                   r_state_q,      w_state_d;
    logic                     r_aw_held_q,    w_aw_held_d;
    logic [31:0]              r_awaddr_q,     w_awaddr_d;
    logic                     r_w_held_q,     w_w_held_d;
    logic [31:0]              r_wdata_q,      w_wdata_d;
    logic [3:0]               r_wstrb_q,      w_wstrb_d;
    logic                     r_awready_q,    w_awready_d;
    logic                     r_wready_q,     w_wready_d;
    logic                     r_bvalid_q,     w_bvalid_d;
    logic                     r_rvalid_q,     w_rvalid_d;
    logic [31:0]              r_rdata_q,      w_rdata_d;
    logic                     r_rdata_live_q, w_rdata_live_d;
    logic                     r_sram_en_q,    w_sram_en_d;
    logic [3:0]               r_sram_we_q,    w_sram_we_d;
    logic [MEM_ADDR_BITS-1:0] r_sram_addr_q,  w_sram_addr_d;
    logic [31:0]              r_sram_wdata_q, w_sram_wdata_d;
    logic                     r_decode_err_q, w_decode_err_d;
    logic [7:0]               r_err_count_q,  w_err_count_d;
    logic                     r_prio_rd_q,    w_prio_rd_d;
    logic [2:0]               r_wait_cnt_q,   w_wait_cnt_d;

    logic w_wr_req;
    logic w_grant_rd;
    logic w_grant_wr;
    logic w_err;
    logic w_unused;

    function automatic logic f_in_window(input logic [31:0] a);
        return (a & ~c_win_mask) == ADDR_BASE;
    endfunction

    assign w_wr_req   = r_aw_held_q && r_w_held_q;
    assign w_grant_rd = (r_state_q == ST_IDLE) && mem_axi_arvalid && (!w_wr_req || r_prio_rd_q);
    assign w_grant_wr = (r_state_q == ST_IDLE) && w_wr_req && !w_grant_rd;

    always_comb begin
        w_state_d      = r_state_q;
        w_aw_held_d    = r_aw_held_q;
        w_awaddr_d     = r_awaddr_q;
        w_w_held_d     = r_w_held_q;
        w_wdata_d      = r_wdata_q;
        w_wstrb_d      = r_wstrb_q;
        w_bvalid_d     = r_bvalid_q;
        w_rvalid_d     = r_rvalid_q;
        w_rdata_d      = r_rdata_live_q ? sram_rdata : r_rdata_q;
        w_rdata_live_d = 1'b0;
        w_sram_en_d    = 1'b0;
        w_sram_we_d    = 4'h0;
        w_sram_addr_d  = r_sram_addr_q;
        w_sram_wdata_d = r_sram_wdata_q;
        w_prio_rd_d    = r_prio_rd_q;
        w_wait_cnt_d   = r_wait_cnt_q;
        w_err          = 1'b0;

        if (mem_axi_awvalid && r_awready_q) begin
            w_aw_held_d = 1'b1;
            w_awaddr_d  = mem_axi_awaddr;
        end
        if (mem_axi_wvalid && r_wready_q) begin
            w_w_held_d = 1'b1;
            w_wdata_d  = mem_axi_wdata;
            w_wstrb_d  = mem_axi_wstrb;
        end

        case (r_state_q)
            ST_IDLE: begin
                if (w_grant_wr) begin
                    w_state_d   = ST_WR;
                    w_aw_held_d = 1'b0;
                    w_w_held_d  = 1'b0;
                    w_prio_rd_d = 1'b1;
                    if (!f_in_window(r_awaddr_q)) begin
                        w_err = 1'b1;
                    end else if (r_wstrb_q != 4'h0) begin
                        // an all-zero strobe would look like a read to the SRAM
                        w_sram_en_d    = 1'b1;
                        w_sram_we_d    = r_wstrb_q;
                        w_sram_addr_d  = r_awaddr_q[MEM_ADDR_BITS+1:2];
                        w_sram_wdata_d = r_wdata_q;
                    end
                end else if (w_grant_rd) begin
                    w_prio_rd_d = 1'b0;
                    if (f_in_window(mem_axi_araddr)) begin
                        w_state_d     = ST_RD_ISSUE;
                        w_sram_en_d   = 1'b1;
                        w_sram_addr_d = mem_axi_araddr[MEM_ADDR_BITS+1:2];
                    end else begin
                        w_state_d  = ST_RRESP;
                        w_rvalid_d = 1'b1;
                        w_rdata_d  = 32'h0000_0000;
                        w_err      = 1'b1;
                    end
                end
            end
            ST_WR: begin
                w_state_d  = ST_WRESP;
                w_bvalid_d = 1'b1;
            end
            ST_WRESP: begin
                if (mem_axi_bready) begin
                    w_state_d  = ST_IDLE;
                    w_bvalid_d = 1'b0;
                end
            end
            ST_RD_ISSUE: begin
                if (READ_LATENCY <= 1) begin
                    w_state_d      = ST_RRESP;
                    w_rvalid_d     = 1'b1;
                    w_rdata_live_d = 1'b1;
                end else begin
                    w_state_d    = ST_RD_WAIT;
                    w_wait_cnt_d = c_wait_init;
                end
            end
            ST_RD_WAIT: begin
                if (r_wait_cnt_q == 3'd0) begin
                    w_state_d      = ST_RRESP;
                    w_rvalid_d     = 1'b1;
                    w_rdata_live_d = 1'b1;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q - 3'd1;
                end
            end
            ST_RRESP: begin
                if (mem_axi_rready) begin
                    w_state_d  = ST_IDLE;
                    w_rvalid_d = 1'b0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_awready_d    = !w_aw_held_d;
        w_wready_d     = !w_w_held_d;
        w_decode_err_d = r_decode_err_q | w_err;
        w_err_count_d  = (w_err && (r_err_count_q != 8'hFF)) ? r_err_count_q + 8'd1 : r_err_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= ST_IDLE;
            r_aw_held_q    <= 1'b0;
            r_awaddr_q     <= 32'h0;
            r_w_held_q     <= 1'b0;
            r_wdata_q      <= 32'h0;
            r_wstrb_q      <= 4'h0;
            r_awready_q    <= 1'b0;
            r_wready_q     <= 1'b0;
            r_bvalid_q     <= 1'b0;
            r_rvalid_q     <= 1'b0;
            r_rdata_q      <= 32'h0;
            r_rdata_live_q <= 1'b0;
            r_sram_en_q    <= 1'b0;
            r_sram_we_q    <= 4'h0;
            r_sram_addr_q  <= '0;
            r_sram_wdata_q <= 32'h0;
            r_decode_err_q <= 1'b0;
            r_err_count_q  <= 8'h0;
            r_prio_rd_q    <= 1'b1;
            r_wait_cnt_q   <= 3'd0;
        end else begin
            r_state_q      <= w_state_d;
            r_aw_held_q    <= w_aw_held_d;
            r_awaddr_q     <= w_awaddr_d;
            r_w_held_q     <= w_w_held_d;
            r_wdata_q      <= w_wdata_d;
            r_wstrb_q      <= w_wstrb_d;
            r_awready_q    <= w_awready_d;
            r_wready_q     <= w_wready_d;
            r_bvalid_q     <= w_bvalid_d;
            r_rvalid_q     <= w_rvalid_d;
            r_rdata_q      <= w_rdata_d;
            r_rdata_live_q <= w_rdata_live_d;
            r_sram_en_q    <= w_sram_en_d;
            r_sram_we_q    <= w_sram_we_d;
            r_sram_addr_q  <= w_sram_addr_d;
            r_sram_wdata_q <= w_sram_wdata_d;
            r_decode_err_q <= w_decode_err_d;
            r_err_count_q  <= w_err_count_d;
            r_prio_rd_q    <= w_prio_rd_d;
            r_wait_cnt_q   <= w_wait_cnt_d;
        end
    end

    // first RRESP cycle passes the SRAM output through; later cycles replay the capture
    assign mem_axi_rdata   = r_rdata_live_q ? sram_rdata : r_rdata_q;
    assign mem_axi_awready = r_awready_q;
    assign mem_axi_wready  = r_wready_q;
    assign mem_axi_bvalid  = r_bvalid_q;
    assign mem_axi_arready = w_grant_rd;
    assign mem_axi_rvalid  = r_rvalid_q;
    assign sram_en         = r_sram_en_q;
    assign sram_we         = r_sram_we_q;
    assign sram_addr       = r_sram_addr_q;
    assign sram_wdata      = r_sram_wdata_q;
    assign decode_err      = r_decode_err_q;
    assign err_count       = r_err_count_q;

    assign w_unused = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_araddr[1:0], r_awaddr_q[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_picorv32_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_picorv32_axi_sram_slave
// Description : Directed self-checking bench with a 1-cycle synchronous SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_picorv32_axi_sram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        decode_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int en_count = 0;
    int wr_count = 0;
    int base;
    logic [31:0] rd_val;
    logic [31:0] mem [0:16383];

    always #5 clk = ~clk;

    picorv32_axi_sram_slave dut (
        .clk(clk), .reset(reset),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
        .mem_axi_bready(bready), .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid),
        .mem_axi_rready(rready), .mem_axi_rdata(rdata), .sram_en(sram_en),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .decode_err(decode_err), .err_count(err_count)
    );

    // synchronous SRAM, read data valid the cycle after the strobe
    always @(posedge clk) begin
        if (sram_en) begin
            en_count <= en_count + 1;
            if (sram_we != 4'h0) begin
                wr_count <= wr_count + 1;
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin step(); n++; end
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin step(); n++; end
        chk("wr_bvalid_seen", {31'b0, bvalid}, 32'd1);
        step();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        arvalid = 1'b1; araddr = a; rready = 1'b0;
        #1;
        n = 0;
        while (!arready && n < 20) begin step(); n++; end
        chk("rd_arready_seen", {31'b0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        chk("rd_rvalid_seen", {31'b0, rvalid}, 32'd1);
        d = rdata;
        rready = 1'b1;
        step();
        rready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
        arvalid = 0; araddr = 0; arprot = 0; rready = 0;
        step(); step();
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_sram_en", {31'b0, sram_en}, 32'd0);
        chk("rst_err_count", {24'b0, err_count}, 32'd0);
        reset = 1'b0;

        // single write, AW and W together
        step();
        chk("t1_awready", {31'b0, awready}, 32'd1);
        chk("t1_wready", {31'b0, wready}, 32'd1);
        awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hA5A5_1234; wstrb = 4'hF;
        step();
        awvalid = 0; wvalid = 0;
        chk("t1_awready_held", {31'b0, awready}, 32'd0);
        chk("t1_en_early", {31'b0, sram_en}, 32'd0);
        step();
        chk("t1_sram_en", {31'b0, sram_en}, 32'd1);
        chk("t1_sram_addr", {18'b0, sram_addr}, 32'd4);
        chk("t1_sram_we", {28'b0, sram_we}, 32'hF);
        chk("t1_sram_wdata", sram_wdata, 32'hA5A5_1234);
        chk("t1_awready_free", {31'b0, awready}, 32'd1);
        step();
        chk("t1_bvalid", {31'b0, bvalid}, 32'd1);
        chk("t1_en_once", {31'b0, sram_en}, 32'd0);
        step();
        chk("t1_bvalid_hold", {31'b0, bvalid}, 32'd1);
        bready = 1;
        step();
        bready = 0;
        chk("t1_bvalid_done", {31'b0, bvalid}, 32'd0);
        chk("t1_decode_err", {31'b0, decode_err}, 32'd0);

        // W three cycles ahead of AW, partial strobe
        base = wr_count;
        wvalid = 1; wdata = 32'hFFFF_1234; wstrb = 4'b0011;
        chk("t2_wready", {31'b0, wready}, 32'd1);
        step();
        wvalid = 0;
        chk("t2_wready_held1", {31'b0, wready}, 32'd0);
        step();
        chk("t2_wready_held2", {31'b0, wready}, 32'd0);
        step();
        chk("t2_no_write_yet", wr_count - base, 32'd0);
        awvalid = 1; awaddr = 32'h10;
        chk("t2_awready", {31'b0, awready}, 32'd1);
        step();
        awvalid = 0;
        chk("t2_wready_held3", {31'b0, wready}, 32'd0);
        step();
        chk("t2_sram_en", {31'b0, sram_en}, 32'd1);
        chk("t2_sram_addr", {18'b0, sram_addr}, 32'd4);
        chk("t2_sram_we", {28'b0, sram_we}, 32'h3);
        chk("t2_wready_wr", {31'b0, wready}, 32'd1);
        bready = 1;
        step();
        chk("t2_bvalid", {31'b0, bvalid}, 32'd1);
        step();
        bready = 0;
        chk("t2_one_write", wr_count - base, 32'd1);

        // in-window read with rready stalled
        arvalid = 1; araddr = 32'h10; rready = 0;
        #1;
        chk("t3_arready", {31'b0, arready}, 32'd1);
        step();
        arvalid = 0;
        chk("t3_sram_en", {31'b0, sram_en}, 32'd1);
        chk("t3_sram_we", {28'b0, sram_we}, 32'h0);
        chk("t3_sram_addr", {18'b0, sram_addr}, 32'd4);
        chk("t3_rvalid_early", {31'b0, rvalid}, 32'd0);
        step();
        chk("t3_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t3_rdata", rdata, 32'hA5A5_1234);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_rvalid_hold", {31'b0, rvalid}, 32'd1);
            chk("t3_rdata_hold", rdata, 32'hA5A5_1234);
        end
        rready = 1;
        step();
        rready = 0;
        chk("t3_rvalid_done", {31'b0, rvalid}, 32'd0);

        // arbitration after a fresh reset
        reset = 1;
        step();
        reset = 0;
        step();
        awvalid = 1; awaddr = 32'h20; wvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        step();
        awvalid = 0; wvalid = 0;
        arvalid = 1; araddr = 32'h10;
        #1;
        chk("t4_read_first", {31'b0, arready}, 32'd1);
        step();
        arvalid = 0;
        chk("t4_rd_en", {31'b0, sram_en}, 32'd1);
        chk("t4_rd_we", {28'b0, sram_we}, 32'h0);
        step();
        chk("t4_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t4_rdata", rdata, 32'hA5A5_1234);
        rready = 1; arvalid = 1; araddr = 32'h20;
        step();
        rready = 0;
        #1;
        chk("t4_write_wins", {31'b0, arready}, 32'd0);
        step();
        chk("t4_wr_en", {31'b0, sram_en}, 32'd1);
        chk("t4_wr_addr", {18'b0, sram_addr}, 32'd8);
        chk("t4_wr_we", {28'b0, sram_we}, 32'hF);
        bready = 1;
        step();
        chk("t4_bvalid", {31'b0, bvalid}, 32'd1);
        step();
        bready = 0;
        #1;
        chk("t4_read_next", {31'b0, arready}, 32'd1);
        step();
        arvalid = 0;
        chk("t4_rd2_addr", {18'b0, sram_addr}, 32'd8);
        rready = 1;
        step();
        chk("t4_rd2_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t4_rd2_rdata", rdata, 32'h0BAD_F00D);
        step();
        rready = 0;

        // out-of-window reads and error saturation
        base = en_count;
        arvalid = 1; araddr = 32'h8000_0000; rready = 0;
        #1;
        chk("t5_arready", {31'b0, arready}, 32'd1);
        step();
        arvalid = 0;
        chk("t5_rvalid", {31'b0, rvalid}, 32'd1);
        chk("t5_rdata", rdata, 32'h0);
        chk("t5_decode_err", {31'b0, decode_err}, 32'd1);
        chk("t5_err_count", {24'b0, err_count}, 32'd1);
        chk("t5_no_en", {31'b0, sram_en}, 32'd0);
        rready = 1;
        step();
        arvalid = 1;
        repeat (598) step();
        arvalid = 0; rready = 0;
        step();
        chk("t5_err_sat", {24'b0, err_count}, 32'd255);
        chk("t5_rvalid_idle", {31'b0, rvalid}, 32'd0);
        chk("t5_no_strobes", en_count - base, 32'd0);

        // out-of-window write, zero-strobe write, then a real write
        axi_write(32'h8000_0010, 32'h5555_5555, 4'hF);
        chk("t5w_no_strobe", en_count - base, 32'd0);
        chk("t5w_err_sat", {24'b0, err_count}, 32'd255);
        axi_write(32'h4, 32'h1234_5678, 4'h0);
        chk("t7_zero_strb_noop", en_count - base, 32'd0);
        axi_write(32'h4, 32'hCAFE_0004, 4'hF);
        chk("t7_real_write", en_count - base, 32'd1);

        // reset in the middle of a read
        arvalid = 1; araddr = 32'h10; rready = 0;
        step();
        arvalid = 0;
        chk("t6_en_before", {31'b0, sram_en}, 32'd1);
        base = en_count;
        #1 reset = 1;
        #1;
        chk("t6_rst_en", {31'b0, sram_en}, 32'd0);
        chk("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("t6_rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("t6_rst_err", {24'b0, err_count}, 32'd0);
        step(); step();
        reset = 0;
        repeat (3) step();
        chk("t6_no_stray_en", en_count - base, 32'd0);
        axi_read(32'h4, rd_val);
        chk("t6_read_data", rd_val, 32'hCAFE_0004);
        chk("t6_one_strobe", en_count - base, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
